wb_rob_multiport: RTL and testbench
===================================

Name: wb_rob_multiport

Overview:
- Parametrised in-order reorder buffer for the writeback stage: next generation of the single-instance ROB.
- Allocates entries at decode and accepts results from NUM_WB_PORTS execution units (ALU, MUL, cache and others) in any order.
- Retires one instruction per cycle to the register file, in program order.
- Raises precise exceptions: on exception retire it flushes the pipeline and empties itself. An optional bypass lookup serves completed, uncommitted results to execution units.

Parameters:
- NUM_ENTRIES, 8, ROB depth; must be a power of two, at least 2.
- ID_W, 3, entry id width; equals log2(NUM_ENTRIES).
- NUM_WB_PORTS, 3, number of writeback channels.
- DATA_W, 32, result width.
- DEST_W, 5, RF destination address width.
- PC_W, 32, PC width.
- XT_W, 2, exception type width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- alloc_valid  in  1  decode requests an entry
- alloc_pc  in  PC_W  PC of the allocating instruction
- alloc_ready  out  1  entry available this cycle
- alloc_id  out  ID_W  id granted; equals the tail pointer
- wb_valid  in  NUM_WB_PORTS  per-port result valid
- wb_id  in  NUM_WB_PORTS*ID_W  per-port entry id; port p occupies bits [p*ID_W +: ID_W]
- wb_data  in  NUM_WB_PORTS*DATA_W  per-port result
- wb_dest  in  NUM_WB_PORTS*DEST_W  per-port RF destination
- wb_we  in  NUM_WB_PORTS  per-port: result writes the RF
- wb_xcpt  in  NUM_WB_PORTS  per-port: instruction raised an exception
- wb_xcpt_type  in  NUM_WB_PORTS*XT_W  per-port exception type
- rf_write_en  out  1  registered RF write strobe
- rf_data  out  DATA_W  RF write data
- rf_dest  out  DEST_W  RF write address
- rf_instr_id  out  ID_W  id of the retired entry
- xcpt_valid  out  1  registered, one-cycle exception pulse
- xcpt_type  out  XT_W  exception type
- xcpt_pc  out  PC_W  PC of the excepting instruction
- flush_pipeline  out  1  one-cycle flush, coincident with xcpt_valid
- rob_full  out  1  count == NUM_ENTRIES
- rob_empty  out  1  count == 0
- rob_oldest  out  ID_W  head pointer
- byp_src_id  in  2*ID_W  two bypass lookup ids (present only with the optional feature)
- byp_hit  out  2  bypass hit flags (present only with the optional feature)
- byp_data  out  2*DATA_W  bypass data (present only with the optional feature)

Behaviour:
- State: head and tail pointers, each ID_W bits, wrapping modulo NUM_ENTRIES. Count is ID_W+1 bits.
- Per entry: valid, done, we, xcpt, xtype, dest, data, pc.
- Reset: all entries invalid; head = tail = count = 0.
- Reset value of every output is 0, except rob_empty = 1 and alloc_ready = 1.
- Allocation:
  - alloc_ready = !rob_full && !flush_pipeline && !commit_xcpt.
  - commit_xcpt = head entry valid && done && xcpt.
  - On alloc_valid && alloc_ready: entry[tail] becomes valid with done = 0 and pc captured; tail increments.
  - alloc_ready is computed from pre-commit count, so a full ROB refuses allocation even in a cycle where it retires.
- Writeback:
  - On wb_valid[p] with entry[wb_id] valid && !done: write data, dest, we, xcpt and xtype; set done.
  - Writeback to an invalid or already-done entry is ignored.
  - Two ports targeting the same id in one cycle: the lowest port index wins; the others are dropped.
  - A writeback to the entry allocated in the same cycle is ignored.
- Commit (at most one per cycle), when the head entry is valid && done:
  - No exception: register rf_write_en = we, plus data, dest and id; invalidate the head entry; head increments; count decrements.
  - Exception: register xcpt_valid = 1, flush_pipeline = 1, xtype and pc; rf_write_en = 0. All entries are invalidated and head = tail = count = 0 at the same edge.
- Commit outputs are valid for exactly one cycle; rf_write_en is 0 when nothing commits.
- Latency: writeback sampled at edge N makes the entry done. If that entry is the head, rf outputs assert during the cycle after edge N+1.
- Simultaneous allocate and commit: count is unchanged; both pointers advance.
- Empty ROB: no commit; writebacks are ignored.
- Reset mid-operation clears all state immediately, asynchronously.

Optional Feature:
- Macro: WB_ROB_BYPASS_EN.
- Defined:
  - byp ports exist.
  - byp_hit[k] = entry[byp_src_id[k]] valid && done && !xcpt; combinational, from stored state only. Same-cycle writebacks are not forwarded.
  - byp_data[k] = entry data when hit, else 0.
- Undefined: byp ports are absent and no lookup mux is built.

Test Plan:
- Allocate 3 (ids 0,1,2); writeback id2 = 0x33, id0 = 0x11, id1 = 0x22 on ports 2,0,1 -> RF writes in order 0x11, 0x22, 0x33 with ids 0,1,2; rob_empty = 1 afterwards.
- Allocate 8 without writeback -> rob_full = 1 and alloc_ready = 0. Then complete id0 while alloc_valid is held -> allocation is accepted only after the commit; tail wraps to 1; alloc_id = 0.
- Allocate 4 (PCs 0x100..0x10C); id1 raises xcpt with type 2; complete id0 and id2 -> id0 retires, then xcpt_valid = 1, xcpt_pc = 0x104, xcpt_type = 2, flush_pipeline = 1 for one cycle; next cycle rob_empty = 1 and head = 0.
- Ports 0 and 1 both write id3 with 0xAA and 0xBB in the same cycle -> id3 retires with 0xAA.
- Bypass enabled: id4 done with 0x5 and not yet committed; byp_src_id = {4,5} with id5 pending -> byp_hit = 2'b01, byp_data[0] = 0x5, byp_data[1] = 0.
- Assert reset while 5 entries are valid -> all outputs take reset values immediately; the first allocation afterwards gets id 0.

Source files
------------

// File: rtl/wb_rob_multiport_if.sv
// ---------------------------------------------------------------------------
// wb_rob_multiport_if
//   Bundles the decode, writeback, retire, exception and status signals of the
//   multi-port writeback reorder buffer.
//   master : the surrounding pipeline (decode + execution units + RF side)
//   slave  : the reorder buffer itself
//   Decode      : alloc_valid, alloc_pc -> alloc_ready, alloc_id
//   Writeback   : wb_valid/wb_id/wb_data/wb_dest/wb_we/wb_xcpt/wb_xcpt_type,
//                 packed per port, port p at [p*W +: W]
//   Retire      : rf_write_en, rf_data, rf_dest, rf_instr_id
//   Exception   : xcpt_valid, xcpt_type, xcpt_pc, flush_pipeline
//   Status      : rob_full, rob_empty, rob_oldest
// ---------------------------------------------------------------------------
interface wb_rob_multiport_if #(
    parameter int ID_W         = 3,
    parameter int NUM_WB_PORTS = 3,
    parameter int DATA_W       = 32,
    parameter int DEST_W       = 5,
    parameter int PC_W         = 32,
    parameter int XT_W         = 2
);
    logic                           alloc_valid;
    logic [PC_W-1:0]                alloc_pc;
    logic                           alloc_ready;
    logic [ID_W-1:0]                alloc_id;

    logic [NUM_WB_PORTS-1:0]        wb_valid;
    logic [NUM_WB_PORTS*ID_W-1:0]   wb_id;
    logic [NUM_WB_PORTS*DATA_W-1:0] wb_data;
    logic [NUM_WB_PORTS*DEST_W-1:0] wb_dest;
    logic [NUM_WB_PORTS-1:0]        wb_we;
    logic [NUM_WB_PORTS-1:0]        wb_xcpt;
    logic [NUM_WB_PORTS*XT_W-1:0]   wb_xcpt_type;

    logic                           rf_write_en;
    logic [DATA_W-1:0]              rf_data;
    logic [DEST_W-1:0]              rf_dest;
    logic [ID_W-1:0]                rf_instr_id;

    logic                           xcpt_valid;
    logic [XT_W-1:0]                xcpt_type;
    logic [PC_W-1:0]                xcpt_pc;
    logic                           flush_pipeline;

    logic                           rob_full;
    logic                           rob_empty;
    logic [ID_W-1:0]                rob_oldest;

    modport master (
        output alloc_valid, alloc_pc,
        output wb_valid, wb_id, wb_data, wb_dest, wb_we, wb_xcpt, wb_xcpt_type,
        input  alloc_ready, alloc_id,
        input  rf_write_en, rf_data, rf_dest, rf_instr_id,
        input  xcpt_valid, xcpt_type, xcpt_pc, flush_pipeline,
        input  rob_full, rob_empty, rob_oldest
    );

    modport slave (
        input  alloc_valid, alloc_pc,
        input  wb_valid, wb_id, wb_data, wb_dest, wb_we, wb_xcpt, wb_xcpt_type,
        output alloc_ready, alloc_id,
        output rf_write_en, rf_data, rf_dest, rf_instr_id,
        output xcpt_valid, xcpt_type, xcpt_pc, flush_pipeline,
        output rob_full, rob_empty, rob_oldest
    );
endinterface

// File: rtl/wb_rob_multiport.sv
// ---------------------------------------------------------------------------
// wb_rob_multiport
//   In-order reorder buffer for the writeback stage. Entries are allocated at
//   decode (tail), completed out of order by NUM_WB_PORTS writeback channels,
//   and retired one per cycle from the head in program order. A completed head
//   entry carrying an exception produces a one-cycle exception/flush pulse and
//   empties the buffer at the same edge.
//
//   Ports
//     clock, reset : clock and asynchronous active-high reset
//     bus (slave)  : decode / writeback / retire / exception / status bundle
//     byp_src_id   : two packed lookup ids           (bypass build only)
//     byp_hit      : per-lookup hit flags            (bypass build only)
//     byp_data     : per-lookup stored result or 0   (bypass build only)
//
//   Build option
//     WB_ROB_BYPASS_EN : when defined, adds a combinational two-read lookup of
//     completed, non-excepting, not yet retired results. Same-cycle writebacks
//     are not forwarded. When undefined the byp ports and mux do not exist.
// ---------------------------------------------------------------------------
module wb_rob_multiport #(
    parameter int NUM_ENTRIES  = 8,
    parameter int ID_W         = 3,
    parameter int NUM_WB_PORTS = 3,
    parameter int DATA_W       = 32,
    parameter int DEST_W       = 5,
    parameter int PC_W         = 32,
    parameter int XT_W         = 2
) (
    input  logic                clock,
    input  logic                reset,
`ifdef WB_ROB_BYPASS_EN
    input  logic [2*ID_W-1:0]   byp_src_id,
    output logic [1:0]          byp_hit,
    output logic [2*DATA_W-1:0] byp_data,
`endif
    wb_rob_multiport_if.slave   bus
);
    localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(NUM_ENTRIES);

    // Entry control bits live under reset; payload fields do not need it
    // because nothing reads them while the entry is invalid.
    logic [NUM_ENTRIES-1:0] ent_valid;
    logic [NUM_ENTRIES-1:0] ent_done;
    logic [NUM_ENTRIES-1:0] ent_we;
    logic [NUM_ENTRIES-1:0] ent_xcpt;
    logic [XT_W-1:0]        ent_xtype [NUM_ENTRIES];
    logic [DEST_W-1:0]      ent_dest  [NUM_ENTRIES];
    logic [DATA_W-1:0]      ent_data  [NUM_ENTRIES];
    logic [PC_W-1:0]        ent_pc    [NUM_ENTRIES];

    logic [ID_W-1:0]        head;
    logic [ID_W-1:0]        tail;
    logic [ID_W:0]          count;

    // Commit-stage output registers
    logic                   rf_write_en_p1;
    logic [DATA_W-1:0]      rf_data_p1;
    logic [DEST_W-1:0]      rf_dest_p1;
    logic [ID_W-1:0]        rf_instr_id_p1;
    logic                   xcpt_valid_p1;
    logic [XT_W-1:0]        xcpt_type_p1;
    logic [PC_W-1:0]        xcpt_pc_p1;

    logic                   rob_full;
    logic                   head_ready;
    logic                   commit_norm;
    logic                   commit_xcpt;
    logic                   alloc_ready;
    logic                   alloc_fire;
    logic [ID_W-1:0]        wb_id_a [NUM_WB_PORTS];
    logic [NUM_WB_PORTS-1:0] wb_take;

    assign rob_full    = (count == FULL_CNT);
    assign head_ready  = ent_valid[head] && ent_done[head];
    assign commit_xcpt = head_ready && ent_xcpt[head];
    assign commit_norm = head_ready && !ent_xcpt[head];
    // Uses the pre-commit count: a full buffer refuses even while it retires.
    // xcpt_valid_p1 doubles as the registered flush pulse.
    assign alloc_ready = !rob_full && !xcpt_valid_p1 && !commit_xcpt;
    assign alloc_fire  = bus.alloc_valid && alloc_ready;

    always_comb begin
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            wb_id_a[p] = bus.wb_id[p*ID_W +: ID_W];
        end
    end

    // A port is taken only if its target is allocated and still pending and
    // no lower-indexed port names the same id this cycle. The entry being
    // allocated now is still invalid here, so writebacks to it drop out.
    always_comb begin
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            wb_take[p] = bus.wb_valid[p] && ent_valid[wb_id_a[p]] && !ent_done[wb_id_a[p]];
            for (int q = 0; q < p; q++) begin
                if (bus.wb_valid[q] && (wb_id_a[q] == wb_id_a[p])) begin
                    wb_take[p] = 1'b0;
                end
            end
        end
    end

    // ---- stage p0 -> p1: entry control, pointers and commit registers ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_valid      <= '0;
            ent_done       <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            rf_write_en_p1 <= 1'b0;
            rf_data_p1     <= '0;
            rf_dest_p1     <= '0;
            rf_instr_id_p1 <= '0;
            xcpt_valid_p1  <= 1'b0;
            xcpt_type_p1   <= '0;
            xcpt_pc_p1     <= '0;
        end else begin
            rf_write_en_p1 <= 1'b0;
            xcpt_valid_p1  <= 1'b0;

            for (int p = 0; p < NUM_WB_PORTS; p++) begin
                if (wb_take[p]) begin
                    ent_done[wb_id_a[p]] <= 1'b1;
                end
            end

            if (alloc_fire) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                tail            <= tail + 1'b1;
            end

            if (commit_norm) begin
                rf_write_en_p1  <= ent_we[head];
                rf_data_p1      <= ent_data[head];
                rf_dest_p1      <= ent_dest[head];
                rf_instr_id_p1  <= head;
                ent_valid[head] <= 1'b0;
                ent_done[head]  <= 1'b0;
                head            <= head + 1'b1;
            end

            case ({alloc_fire, commit_norm})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Precise exception: everything younger is squashed at this edge,
            // overriding any writeback recorded above.
            if (commit_xcpt) begin
                xcpt_valid_p1 <= 1'b1;
                xcpt_type_p1  <= ent_xtype[head];
                xcpt_pc_p1    <= ent_pc[head];
                ent_valid     <= '0;
                ent_done      <= '0;
                head          <= '0;
                tail          <= '0;
                count         <= '0;
            end
        end
    end

    // ---- stage p0 -> p1: entry payload ----
    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            if (wb_take[p]) begin
                ent_data[wb_id_a[p]]  <= bus.wb_data[p*DATA_W +: DATA_W];
                ent_dest[wb_id_a[p]]  <= bus.wb_dest[p*DEST_W +: DEST_W];
                ent_we[wb_id_a[p]]    <= bus.wb_we[p];
                ent_xcpt[wb_id_a[p]]  <= bus.wb_xcpt[p];
                ent_xtype[wb_id_a[p]] <= bus.wb_xcpt_type[p*XT_W +: XT_W];
            end
        end
        if (alloc_fire) begin
            ent_pc[tail] <= bus.alloc_pc;
        end
    end

`ifdef WB_ROB_BYPASS_EN
    logic [ID_W-1:0] byp_id [2];

    always_comb begin
        byp_hit  = '0;
        byp_data = '0;
        for (int k = 0; k < 2; k++) begin
            byp_id[k]  = byp_src_id[k*ID_W +: ID_W];
            byp_hit[k] = ent_valid[byp_id[k]] && ent_done[byp_id[k]] && !ent_xcpt[byp_id[k]];
            if (byp_hit[k]) begin
                byp_data[k*DATA_W +: DATA_W] = ent_data[byp_id[k]];
            end
        end
    end
`endif

    assign bus.alloc_ready    = alloc_ready;
    assign bus.alloc_id       = tail;
    assign bus.rf_write_en    = rf_write_en_p1;
    assign bus.rf_data        = rf_data_p1;
    assign bus.rf_dest        = rf_dest_p1;
    assign bus.rf_instr_id    = rf_instr_id_p1;
    assign bus.xcpt_valid     = xcpt_valid_p1;
    assign bus.xcpt_type      = xcpt_type_p1;
    assign bus.xcpt_pc        = xcpt_pc_p1;
    assign bus.flush_pipeline = xcpt_valid_p1;
    assign bus.rob_full       = rob_full;
    assign bus.rob_empty      = (count == '0);
    assign bus.rob_oldest     = head;
endmodule

// File: tb/tb_wb_rob_multiport.sv
// ---------------------------------------------------------------------------
// tb_wb_rob_multiport
//   Directed scenarios followed by randomized traffic for wb_rob_multiport.
//   The reference keeps the buffer as a program-ordered queue of instruction
//   records and derives every expected output from that queue.
// ---------------------------------------------------------------------------
module tb_wb_rob_multiport;
    localparam int NE  = 8;
    localparam int IDW = 3;
    localparam int NP  = 3;
    localparam int DW  = 32;
    localparam int DSW = 5;
    localparam int PW  = 32;
    localparam int XW  = 2;

    logic clock;
    logic reset;

    wb_rob_multiport_if #(.ID_W(IDW), .NUM_WB_PORTS(NP), .DATA_W(DW),
                          .DEST_W(DSW), .PC_W(PW), .XT_W(XW)) bus ();

`ifdef WB_ROB_BYPASS_EN
    logic [2*IDW-1:0] byp_src_id;
    logic [1:0]       byp_hit;
    logic [2*DW-1:0]  byp_data;
`endif

    wb_rob_multiport #(.NUM_ENTRIES(NE), .ID_W(IDW), .NUM_WB_PORTS(NP), .DATA_W(DW),
                       .DEST_W(DSW), .PC_W(PW), .XT_W(XW)) dut (
        .clock      (clock),
        .reset      (reset),
`ifdef WB_ROB_BYPASS_EN
        .byp_src_id (byp_src_id),
        .byp_hit    (byp_hit),
        .byp_data   (byp_data),
`endif
        .bus        (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int             id;
        logic [PW-1:0]  pc;
        bit             done;
        bit             we;
        bit             xc;
        logic [XW-1:0]  xt;
        logic [DSW-1:0] dest;
        logic [DW-1:0]  data;
    } ent_t;

    ent_t           mq[$];      // in-flight instructions, oldest first
    int             m_tail;     // id the next allocation receives
    logic [DW-1:0]  rf_log[$];  // data of every observed RF write

    // Expected registered outputs after the most recent edge
    bit             e_rfwe, e_rf_chk, e_xv;
    logic [DW-1:0]  e_rfdata;
    logic [DSW-1:0] e_rfdest;
    logic [IDW-1:0] e_rfid;
    logic [XW-1:0]  e_xt;
    logic [PW-1:0]  e_xpc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.alloc_valid  = 1'b0;
        bus.alloc_pc     = '0;
        bus.wb_valid     = '0;
        bus.wb_id        = '0;
        bus.wb_data      = '0;
        bus.wb_dest      = '0;
        bus.wb_we        = '0;
        bus.wb_xcpt      = '0;
        bus.wb_xcpt_type = '0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_tail   = 0;
        e_rfwe   = 0;
        e_rf_chk = 0;
        e_xv     = 0;
    endtask

    task automatic check_reset_vals();
        chk("rst_rf_write_en", bus.rf_write_en, 0);
        chk("rst_rf_data", bus.rf_data, 0);
        chk("rst_rf_dest", bus.rf_dest, 0);
        chk("rst_rf_instr_id", bus.rf_instr_id, 0);
        chk("rst_xcpt_valid", bus.xcpt_valid, 0);
        chk("rst_xcpt_type", bus.xcpt_type, 0);
        chk("rst_xcpt_pc", bus.xcpt_pc, 0);
        chk("rst_flush", bus.flush_pipeline, 0);
        chk("rst_rob_full", bus.rob_full, 0);
        chk("rst_rob_empty", bus.rob_empty, 1);
        chk("rst_rob_oldest", bus.rob_oldest, 0);
        chk("rst_alloc_id", bus.alloc_id, 0);
        chk("rst_alloc_ready", bus.alloc_ready, 1);
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_vals();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_outputs();
        bit exp_rdy;
        exp_rdy = (mq.size() != NE) && !e_xv && !(mq.size() > 0 && mq[0].done && mq[0].xc);
        chk("rf_write_en", bus.rf_write_en, e_rfwe);
        if (e_rf_chk) begin
            chk("rf_data", bus.rf_data, e_rfdata);
            chk("rf_dest", bus.rf_dest, e_rfdest);
            chk("rf_instr_id", bus.rf_instr_id, e_rfid);
        end
        chk("xcpt_valid", bus.xcpt_valid, e_xv);
        chk("flush_pipeline", bus.flush_pipeline, e_xv);
        if (e_xv) begin
            chk("xcpt_type", bus.xcpt_type, e_xt);
            chk("xcpt_pc", bus.xcpt_pc, e_xpc);
        end
        chk("rob_full", bus.rob_full, mq.size() == NE);
        chk("rob_empty", bus.rob_empty, mq.size() == 0);
        chk("rob_oldest", bus.rob_oldest, (mq.size() > 0) ? mq[0].id : m_tail);
        chk("alloc_id", bus.alloc_id, m_tail);
        chk("alloc_ready", bus.alloc_ready, exp_rdy);
`ifdef WB_ROB_BYPASS_EN
        for (int k = 0; k < 2; k++) begin
            int            sid;
            bit            eh;
            logic [DW-1:0] ed;
            sid = int'(byp_src_id[k*IDW +: IDW]);
            eh  = 0;
            ed  = '0;
            foreach (mq[i]) begin
                if (mq[i].id == sid && mq[i].done && !mq[i].xc) begin
                    eh = 1;
                    ed = mq[i].data;
                end
            end
            chk("byp_hit", byp_hit[k], eh);
            chk("byp_data", byp_data[k*DW +: DW], ed);
        end
`endif
        if (bus.rf_write_en === 1'b1) rf_log.push_back(bus.rf_data);
    endtask

    // Advance the reference by one edge using the inputs currently driven,
    // then clock the DUT and compare.
    task automatic cycle();
        bit   full, hd, cx, rdy;
        bit   claimed[NE];
        int   wid;
        ent_t e;
        full = (mq.size() == NE);
        hd   = (mq.size() > 0) && mq[0].done;
        cx   = hd && mq[0].xc;
        rdy  = !full && !e_xv && !cx;
        foreach (claimed[i]) claimed[i] = 0;
        for (int p = 0; p < NP; p++) begin
            if (bus.wb_valid[p]) begin
                wid = int'(bus.wb_id[p*IDW +: IDW]);
                if (!claimed[wid]) begin
                    claimed[wid] = 1;
                    foreach (mq[i]) begin
                        if (mq[i].id == wid && !mq[i].done) begin
                            mq[i].done = 1;
                            mq[i].data = bus.wb_data[p*DW +: DW];
                            mq[i].dest = bus.wb_dest[p*DSW +: DSW];
                            mq[i].we   = bus.wb_we[p];
                            mq[i].xc   = bus.wb_xcpt[p];
                            mq[i].xt   = bus.wb_xcpt_type[p*XW +: XW];
                        end
                    end
                end
            end
        end
        e_rfwe   = 0;
        e_rf_chk = 0;
        e_xv     = 0;
        if (cx) begin
            e_xv  = 1;
            e_xt  = mq[0].xt;
            e_xpc = mq[0].pc;
            mq.delete();
            m_tail = 0;
        end else if (hd) begin
            e_rfwe   = mq[0].we;
            e_rfdata = mq[0].data;
            e_rfdest = mq[0].dest;
            e_rfid   = IDW'(mq[0].id);
            e_rf_chk = 1;
            void'(mq.pop_front());
        end
        if (bus.alloc_valid && rdy) begin
            e = '{id: m_tail, pc: bus.alloc_pc, done: 0, we: 0, xc: 0, xt: '0, dest: '0, data: '0};
            mq.push_back(e);
            m_tail = (m_tail + 1) % NE;
        end
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic alloc(input logic [PW-1:0] pc);
        bus.alloc_valid = 1'b1;
        bus.alloc_pc    = pc;
        cycle();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic set_wb(input int p, input int id, input logic [DW-1:0] d,
                          input bit we, input bit xc, input logic [XW-1:0] xt);
        bus.wb_valid[p]              = 1'b1;
        bus.wb_id[p*IDW +: IDW]      = IDW'(id);
        bus.wb_data[p*DW +: DW]      = d;
        bus.wb_dest[p*DSW +: DSW]    = DSW'(id + 1);
        bus.wb_we[p]                 = we;
        bus.wb_xcpt[p]               = xc;
        bus.wb_xcpt_type[p*XW +: XW] = xt;
    endtask

    initial begin
        reset = 1'b1;
`ifdef WB_ROB_BYPASS_EN
        byp_src_id = '0;
`endif
        idle();
        apply_reset();

        // Out-of-order completion, in-order retirement
        rf_log.delete();
        for (int i = 0; i < 3; i++) alloc(PW'(32'h40 + 4 * i));
        set_wb(2, 2, 32'h33, 1, 0, 0); cycle(); idle();
        set_wb(0, 0, 32'h11, 1, 0, 0); cycle(); idle();
        set_wb(1, 1, 32'h22, 1, 0, 0); cycle(); idle();
        for (int i = 0; i < 4; i++) cycle();
        chk("inorder_count", rf_log.size(), 3);
        if (rf_log.size() == 3) begin
            chk("inorder_0", rf_log[0], 32'h11);
            chk("inorder_1", rf_log[1], 32'h22);
            chk("inorder_2", rf_log[2], 32'h33);
        end
        chk("inorder_empty", bus.rob_empty, 1);

        // Full buffer refuses allocation until after the retiring edge
        apply_reset();
        for (int i = 0; i < NE; i++) alloc(PW'(32'h200 + 4 * i));
        chk("full_flag", bus.rob_full, 1);
        chk("full_ready", bus.alloc_ready, 0);
        bus.alloc_valid = 1'b1;
        bus.alloc_pc    = 32'h900;
        set_wb(0, 0, 32'h77, 1, 0, 0);
        cycle();
        bus.wb_valid = '0;
        chk("full_wb_ready", bus.alloc_ready, 0);
        cycle();
        chk("full_commit_ready", bus.alloc_ready, 1);
        chk("full_commit_id", bus.alloc_id, 0);
        cycle();
        chk("full_wrap_id", bus.alloc_id, 1);
        chk("full_again", bus.rob_full, 1);
        idle();

        // Precise exception on id1
        apply_reset();
        for (int i = 0; i < 4; i++) alloc(PW'(32'h100 + 4 * i));
        set_wb(0, 1, 32'hDEAD, 1, 1, 2'd2); cycle(); idle();
        set_wb(1, 0, 32'h1, 1, 0, 0); cycle(); idle();
        set_wb(2, 2, 32'h2, 1, 0, 0); cycle(); idle();
        chk("xc_id0_we", bus.rf_write_en, 1);
        chk("xc_id0_id", bus.rf_instr_id, 0);
        cycle();
        chk("xc_valid", bus.xcpt_valid, 1);
        chk("xc_pc", bus.xcpt_pc, 32'h104);
        chk("xc_type", bus.xcpt_type, 2);
        chk("xc_flush", bus.flush_pipeline, 1);
        chk("xc_no_rf", bus.rf_write_en, 0);
        cycle();
        chk("xc_pulse_end", bus.xcpt_valid, 0);
        chk("xc_empty", bus.rob_empty, 1);
        chk("xc_head", bus.rob_oldest, 0);

        // Two ports hit the same id: lowest port wins
        apply_reset();
        rf_log.delete();
        for (int i = 0; i < 4; i++) alloc(PW'(32'h300 + 4 * i));
        set_wb(0, 0, 32'h10, 1, 0, 0);
        set_wb(1, 1, 32'h20, 1, 0, 0);
        set_wb(2, 2, 32'h30, 1, 0, 0);
        cycle(); idle();
        set_wb(0, 3, 32'hAA, 1, 0, 0);
        set_wb(1, 3, 32'hBB, 1, 0, 0);
        cycle(); idle();
        for (int i = 0; i < 5; i++) cycle();
        chk("dual_count", rf_log.size(), 4);
        if (rf_log.size() == 4) chk("dual_winner", rf_log[3], 32'hAA);

`ifdef WB_ROB_BYPASS_EN
        // Lookup of a completed but unretired entry next to a pending one
        apply_reset();
        for (int i = 0; i < 6; i++) alloc(PW'(32'h400 + 4 * i));
        set_wb(0, 4, 32'h5, 1, 0, 0); cycle(); idle();
        byp_src_id[0 +: IDW]   = IDW'(4);
        byp_src_id[IDW +: IDW] = IDW'(5);
        #1;
        chk("byp_hit_pair", byp_hit, 2'b01);
        chk("byp_data0", byp_data[0 +: DW], 32'h5);
        chk("byp_data1", byp_data[DW +: DW], 0);
`endif

        // Asynchronous reset with five entries in flight
        apply_reset();
        for (int i = 0; i < 5; i++) alloc(PW'(32'h500 + 4 * i));
        chk("pre_rst_oldest_busy", bus.rob_empty, 0);
        #2;
        apply_reset();
        chk("post_rst_alloc_id", bus.alloc_id, 0);
        alloc(32'h600);
        chk("post_rst_oldest", bus.rob_oldest, 0);
        chk("post_rst_next", bus.alloc_id, 1);

        // Randomized traffic
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            bus.alloc_valid = ($urandom_range(0, 99) < 55);
            bus.alloc_pc    = $urandom;
            for (int p = 0; p < NP; p++) begin
                int rid;
                rid = (mq.size() > 0 && $urandom_range(0, 99) < 80)
                      ? mq[$urandom_range(0, mq.size() - 1)].id
                      : int'($urandom_range(0, NE - 1));
                bus.wb_valid[p] = ($urandom_range(0, 99) < 45);
                bus.wb_id[p*IDW +: IDW]      = IDW'(rid);
                bus.wb_data[p*DW +: DW]      = $urandom;
                bus.wb_dest[p*DSW +: DSW]    = DSW'($urandom_range(0, 31));
                bus.wb_we[p]                 = ($urandom_range(0, 99) < 80);
                bus.wb_xcpt[p]               = ($urandom_range(0, 99) < 4);
                bus.wb_xcpt_type[p*XW +: XW] = XW'($urandom_range(0, 3));
            end
`ifdef WB_ROB_BYPASS_EN
            byp_src_id = (2*IDW)'($urandom);
`endif
            cycle();
        end
        idle();
        for (int i = 0; i < 12; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
